// File: rtl/fir_stream_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_stream_ctrl_if                                            |
// | Purpose  : Bundles the control, sample-memory, filter and capture        |
// |            signals of fir_stream_ctrl.                                   |
// |            master = the sequencer; slave = its environment (RAM, filter, |
// |            host).                                                        |
// | Signals  : start/stop/loop_en/last_addr   host control                   |
// |            mem_addr/mem_rdata             synchronous sample RAM         |
// |            fir_din/fir_dout               fir_filter data in/out         |
// |            out_data/out_valid             captured response              |
// |            busy/done/pass_cnt             status                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface fir_stream_ctrl_if #(
    parameter int N  = 16,
    parameter int AW = 5
);
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_rdata;
    logic [N-1:0]  fir_din;
    logic [N-1:0]  fir_dout;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic [7:0]    pass_cnt;

    modport master (
        input  start, stop, loop_en, last_addr, mem_rdata, fir_dout,
        output mem_addr, fir_din, out_data, out_valid, busy, done, pass_cnt
    );

    modport slave (
        output start, stop, loop_en, last_addr, mem_rdata, fir_dout,
        input  mem_addr, fir_din, out_data, out_valid, busy, done, pass_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fir_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_stream_ctrl                                               |
// | Purpose  : Plays a stored sample record from a synchronous RAM through   |
// |            fir_filter, appends TAPS zero samples to flush the filter     |
// |            tail and captures the response tagged with out_valid.         |
// |            Supports single-shot, looping and early stop.                 |
// | Ports    : clk    - clock, rising edge                                   |
// |            reset  - synchronous, active-low                              |
// |            bus    - fir_stream_ctrl_if.master (control, RAM, filter,     |
// |                     capture and status signals)                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fir_stream_ctrl #(
    parameter int N       = 16,
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TAPS    = 8,
    parameter int FIR_LAT = 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    fir_stream_ctrl_if.master    bus
);

    // Tag pipeline: stage 0 is aligned with mem_addr, stage 2 with fir_din,
    // and out_valid is registered from the last stage.
    localparam int            c_TL         = FIR_LAT + 3;
    localparam int            c_DW         = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [c_DW-1:0] c_DRAIN_INIT = c_DW'(TAPS - 1);
    localparam logic [AW-1:0] c_MAX_ADDR   = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_last;
    logic [AW-1:0]   r_addr;
    logic [c_TL-1:0] r_tag;
    logic [1:0]      r_zero;       // slot is a flush zero, not a record sample
    logic [c_DW-1:0] r_drain_cnt;
    logic [N-1:0]    r_fir_din;
    logic [N-1:0]    r_out_data;
    logic            r_out_valid;
    logic            r_busy;
    logic            r_done;
    logic [7:0]      r_pass_cnt;

    logic            w_at_last;
    logic [7:0]      w_pass_next;

    assign w_at_last   = (r_addr == r_last);
    assign w_pass_next = (r_pass_cnt == 8'hFF) ? r_pass_cnt : r_pass_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_last      <= '0;
            r_addr      <= '0;
            r_tag       <= '0;
            r_zero      <= '0;
            r_drain_cnt <= '0;
            r_fir_din   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass_cnt  <= '0;
        end else begin
            // Slot pipeline always advances; stage 0 is loaded by the FSM.
            r_tag[c_TL-1:1] <= r_tag[c_TL-2:0];
            r_zero[1]       <= r_zero[0];
            r_tag[0]        <= 1'b0;
            r_zero[0]       <= 1'b0;

            // RAM data for a slot arrives one cycle after its address, so the
            // stage-1 tag decides whether it is a record sample. Every other
            // slot (flush, idle) presents zero to the filter. Record samples
            // still in flight keep flowing during the first DRAIN cycles so
            // the response stays contiguous.
            r_fir_din   <= (r_tag[1] && !r_zero[1]) ? bus.mem_rdata : '0;
            r_out_data  <= bus.fir_dout;
            r_out_valid <= r_tag[c_TL-1];
            r_done      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_last     <= (bus.last_addr > c_MAX_ADDR) ? c_MAX_ADDR
                                                                   : bus.last_addr;
                        r_addr     <= '0;
                        r_pass_cnt <= '0;
                        r_tag[0]   <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (w_at_last) begin
                        r_pass_cnt <= w_pass_next;
                    end
                    if (bus.stop || (w_at_last && !bus.loop_en)) begin
                        // Current address was the last one issued; first
                        // flush slot goes out on the transition.
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= c_DRAIN_INIT;
                        r_tag[0]    <= 1'b1;
                        r_zero[0]   <= 1'b1;
                    end else begin
                        r_addr   <= w_at_last ? '0 : r_addr + AW'(1);
                        r_tag[0] <= 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - c_DW'(1);
                        r_tag[0]    <= 1'b1;
                        r_zero[0]   <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (r_tag == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr  = r_addr;
    assign bus.fir_din   = r_fir_din;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass_cnt  = r_pass_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fir_stream_ctrl                                            |
// | Purpose  : Self-checking bench for fir_stream_ctrl with a synchronous    |
// |            RAM model (M[i] = i+1) and an identity filter stub of one     |
// |            cycle latency; captured outputs are scored against a queue.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fir_stream_ctrl;
    localparam int N     = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int TAPS  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fir_stream_ctrl_if #(.N(N), .AW(AW)) bus ();

    fir_stream_ctrl #(
        .N(N), .DEPTH(DEPTH), .AW(AW), .TAPS(TAPS), .FIR_LAT(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [N-1:0] mem [DEPTH];

    // Synchronous RAM and identity filter with one cycle of latency.
    always @(posedge clk) begin
        bus.mem_rdata <= mem[bus.mem_addr];
        bus.fir_dout  <= bus.fir_din;
    end

    logic [N-1:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int n_rise   = 0;
    bit sb_en    = 1'b0;
    logic prev_v = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.done === 1'b1) n_done++;
        if (bus.out_valid === 1'b1 && prev_v !== 1'b1) n_rise++;
        prev_v = bus.out_valid;
        if (sb_en && bus.out_valid === 1'b1) begin
            n_checks++;
            assert (exp_q.size() > 0) n_pass++;
            else $error("FAIL sb_extra_output: observed data %0h expected no valid output",
                        bus.out_data);
            if (exp_q.size() > 0) check("sb_data", bus.out_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [AW-1:0] la, input logic le);
        @(negedge clk);
        bus.last_addr = la;
        bus.loop_en   = le;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd1);
        @(negedge clk);
        check({tag, "_one_cycle"}, {31'd0, bus.done}, 32'd0);
    endtask

    task automatic push_zeros();
        for (int i = 0; i < TAPS; i++) exp_q.push_back('0);
    endtask

    int done0;
    int rise0;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = N'(i + 1);
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.loop_en   = 1'b0;
        bus.last_addr = '0;
        repeat (3) tick();
        check("rst_mem_addr",  bus.mem_addr,  0);
        check("rst_fir_din",   bus.fir_din,   0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy",      bus.busy,      0);
        check("rst_done",      bus.done,      0);
        check("rst_pass_cnt",  bus.pass_cnt,  0);
        reset = 1'b1;
        repeat (2) tick();

        // Full single-shot record 1..32 followed by the flush zeros.
        sb_en = 1'b1;
        for (int i = 0; i < 32; i++) exp_q.push_back(N'(i + 1));
        push_zeros();
        done0 = n_done;
        rise0 = n_rise;
        do_start(5'd31, 1'b0);
        check("full_busy", bus.busy, 1);
        wait_done("full_done");
        check("full_sb_drained", exp_q.size(), 0);
        check("full_pass_cnt",   bus.pass_cnt, 1);
        check("full_busy_end",   bus.busy, 0);
        check("full_done_count", n_done - done0, 1);
        check("full_contiguous", n_rise - rise0, 1);

        // Looping over a 4-sample record, then dropping loop_en.
        for (int k = 0; k < 12; k++) exp_q.push_back(N'((k % 4) + 1));
        push_zeros();
        do_start(5'd3, 1'b1);
        for (int k = 0; k < 10; k++) begin
            check("loop_addr", bus.mem_addr, k % 4);
            check("loop_pass", bus.pass_cnt, k / 4);
            if (k < 9) tick();
        end
        bus.loop_en = 1'b0;
        wait_done("loop_done");
        check("loop_sb_drained", exp_q.size(), 0);
        check("loop_pass_cnt",   bus.pass_cnt, 3);

        // Early stop while address 10 is on the bus.
        for (int i = 0; i <= 10; i++) exp_q.push_back(N'(i + 1));
        push_zeros();
        do_start(5'd31, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            check("stop_addr", bus.mem_addr, k);
            if (k < 10) tick();
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("stop_addr_hold", bus.mem_addr, 10);
        wait_done("stop_done");
        check("stop_sb_drained", exp_q.size(), 0);
        check("stop_pass_cnt",   bus.pass_cnt, 0);

        // Reset in the middle of RUN.
        sb_en = 1'b0;
        do_start(5'd31, 1'b0);
        repeat (6) tick();
        reset = 1'b0;
        repeat (5) tick();
        check("rrun_mem_addr",  bus.mem_addr,  0);
        check("rrun_fir_din",   bus.fir_din,   0);
        check("rrun_out_data",  bus.out_data,  0);
        check("rrun_out_valid", bus.out_valid, 0);
        check("rrun_busy",      bus.busy,      0);
        check("rrun_done",      bus.done,      0);
        check("rrun_pass_cnt",  bus.pass_cnt,  0);
        reset = 1'b1;
        done0 = n_done;
        rise0 = n_rise;
        repeat (60) tick();
        check("rrun_no_done",  n_done - done0, 0);
        check("rrun_no_valid", n_rise - rise0, 0);

        // Reset during DRAIN (record 0..3, DRAIN from cycle 4).
        do_start(5'd3, 1'b0);
        repeat (6) tick();
        check("rdrain_busy_before", bus.busy, 1);
        reset = 1'b0;
        tick();
        check("rdrain_busy",      bus.busy,      0);
        check("rdrain_out_valid", bus.out_valid, 0);
        check("rdrain_done",      bus.done,      0);
        reset = 1'b1;
        done0 = n_done;
        rise0 = n_rise;
        repeat (30) tick();
        check("rdrain_no_done",  n_done - done0, 0);
        check("rdrain_no_valid", n_rise - rise0, 0);

        // One-sample record; start with stop in IDLE, starts while busy ignored.
        sb_en = 1'b1;
        exp_q.push_back(N'(1));
        push_zeros();
        done0 = n_done;
        @(negedge clk);
        bus.last_addr = '0;
        bus.loop_en   = 1'b0;
        bus.start     = 1'b1;
        bus.stop      = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        check("one_start_wins", bus.busy, 1);
        repeat (2) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("one_done");
        check("one_sb_drained",  exp_q.size(), 0);
        check("one_pass_cnt",    bus.pass_cnt, 1);
        check("one_done_count",  n_done - done0, 1);
        repeat (5) tick();
        check("one_idle_after",  bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
